// File: rtl/riscv_biu_pkg.sv
// Shared AHB definitions for the riscv_biu bus interface unit.
// Holds the AHB transfer/response encodings, the HSIZE-aligned size type,
// the SINGLE burst constant and the address alignment check used to
// decide whether a request may reach the bus at all.
package riscv_biu_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3
    } biu_size_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Only the three lowest address bits can matter for sizes up to a dword.
    // Sizes wider than the bus are always treated as misaligned.
    function automatic logic is_misaligned(input logic [2:0] adr_lo,
                                           input logic [2:0] size,
                                           input logic [2:0] max_size);
        logic [3:0] mask;
        if (size > max_size) begin
            return 1'b1;
        end
        mask = (4'b0001 << size) - 4'b0001;
        return |({1'b0, adr_lo} & mask);
    endfunction

endpackage

// File: rtl/riscv_biu_rr_arbiter.sv
// Channel arbiter for riscv_biu_arb.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   elig       : per-channel eligible vector
//   accept     : the current winner was taken this cycle (advances pointer)
//   gnt        : one-hot winner
//   gnt_idx    : binary index of the winner
//   gnt_vld    : a winner exists
// ARB_RR=0 gives fixed priority (channel 0 highest); ARB_RR=1 searches
// from a rotating pointer that moves past each accepted winner.
module riscv_biu_rr_arbiter #(
    parameter int NCH    = 2,
    parameter int ARB_RR = 0,
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   elig,
    input  logic             accept,
    output logic [NCH-1:0]   gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    import riscv_biu_pkg::*;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               start_idx;
    int               cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_vld   = 1'b0;
        cand      = 0;
        start_idx = (ARB_RR != 0) ? int'(ptr_q) : 0;
        for (int i = 0; i < NCH; i++) begin
            cand = start_idx + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!gnt_vld && elig[cand]) begin
                gnt_vld   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && gnt_vld) begin
            ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/riscv_biu_arb.sv
// Multi-channel AHB bus interface unit.
// Merges NCH core-side request channels onto one AHB master port using
// single NONSEQ transfers with overlapped address/data phases.
// Ports:
//   hclk, hreset_n            : clock, asynchronous active-low reset
//   ch_req/we/size/adr/d      : per-channel request (held until ch_ack)
//   ch_q, ch_ack, ch_err      : shared read data, per-channel ack/error pulse
//   hbusreq, hgrant           : AHB bus request / grant
//   haddr..hmasterlock        : AHB master address/control/write data
//   hready, hrdata, hresp     : AHB slave response
module riscv_biu_arb #(
    parameter int         XLEN      = 32,
    parameter int         NCH       = 2,
    parameter int         ARB_RR    = 0,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                hclk,
    input  logic                hreset_n,
    input  logic [NCH-1:0]      ch_req,
    input  logic [NCH-1:0]      ch_we,
    input  logic [3*NCH-1:0]    ch_size,
    input  logic [XLEN*NCH-1:0] ch_adr,
    input  logic [XLEN*NCH-1:0] ch_d,
    output logic [XLEN-1:0]     ch_q,
    output logic [NCH-1:0]      ch_ack,
    output logic [NCH-1:0]      ch_err,
    output logic                hbusreq,
    input  logic                hgrant,
    output logic [XLEN-1:0]     haddr,
    output logic [1:0]          htrans,
    output logic [2:0]          hsize,
    output logic [2:0]          hburst,
    output logic [3:0]          hprot,
    output logic                hwrite,
    output logic [XLEN-1:0]     hwdata,
    output logic                hmasterlock,
    input  logic                hready,
    input  logic [XLEN-1:0]     hrdata,
    input  logic [1:0]          hresp
);
    import riscv_biu_pkg::*;

    localparam int        IDX_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam biu_size_t MAX_SIZE = (XLEN == 64) ? SIZE_DWORD : SIZE_WORD;

    htrans_t          htrans_q, htrans_d;
    logic [XLEN-1:0]  haddr_q, haddr_d;
    logic [2:0]       hsize_q, hsize_d;
    logic             hwrite_q, hwrite_d;
    logic [XLEN-1:0]  hwdata_q, hwdata_d;
    logic             hbusreq_q, hbusreq_d;
    logic [NCH-1:0]   ack_q, ack_d;
    logic [NCH-1:0]   err_q, err_d;
    logic [XLEN-1:0]  q_q, q_d;
    logic [NCH-1:0]   busy_q, busy_d;
    // Channel and write data belonging to the address phase on the bus.
    logic [IDX_W-1:0] ap_ch_q, ap_ch_d;
    logic [XLEN-1:0]  ap_wdata_q, ap_wdata_d;
    // Data phase currently in flight.
    logic             dp_vld_q, dp_vld_d;
    logic [IDX_W-1:0] dp_ch_q, dp_ch_d;
    logic             dp_we_q, dp_we_d;

    logic [NCH-1:0]   mis;
    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   arb_elig;
    logic [NCH-1:0]   gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             accept;
    logic             resp_err;

    always_comb begin
        mis = '0;
        for (int k = 0; k < NCH; k++) begin
            mis[k] = is_misaligned(ch_adr[k*XLEN +: 3], ch_size[3*k +: 3], MAX_SIZE);
        end
    end

    assign elig     = ch_req & ~busy_q;
    // Without the bus, only misaligned requests can be retired (they never
    // touch the bus).
    assign arb_elig = hgrant ? elig : (elig & mis);
    assign accept   = hready & gnt_vld;
    // RETRY and SPLIT are folded into ERROR.
    assign resp_err = (hresp_t'(hresp) != HRESP_OKAY);

    riscv_biu_rr_arbiter #(
        .NCH    (NCH),
        .ARB_RR (ARB_RR)
    ) u_arb (
        .clk     (hclk),
        .rst_n   (hreset_n),
        .elig    (arb_elig),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hsize_d    = hsize_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        ap_ch_d    = ap_ch_q;
        ap_wdata_d = ap_wdata_q;
        dp_vld_d   = dp_vld_q;
        dp_ch_d    = dp_ch_q;
        dp_we_d    = dp_we_q;
        q_d        = q_q;
        ack_d      = '0;
        err_d      = '0;
        // A channel becomes eligible again the cycle after its ack.
        busy_d     = busy_q & ~ack_q;
        hbusreq_d  = (|(elig & ~mis)) | (htrans_q == HTRANS_NONSEQ);

        if (hready) begin
            if (dp_vld_q) begin
                ack_d[dp_ch_q] = 1'b1;
                err_d[dp_ch_q] = resp_err;
                if (!dp_we_q) begin
                    q_d = hrdata;
                end
            end
            // Address phase on the bus is accepted and becomes the data phase.
            dp_vld_d = (htrans_q == HTRANS_NONSEQ);
            if (htrans_q == HTRANS_NONSEQ) begin
                dp_ch_d  = ap_ch_q;
                dp_we_d  = hwrite_q;
                hwdata_d = ap_wdata_q;
            end
            htrans_d = HTRANS_IDLE;
            if (gnt_vld) begin
                busy_d = busy_d | gnt;
                if (mis[gnt_idx]) begin
                    ack_d[gnt_idx] = 1'b1;
                    err_d[gnt_idx] = 1'b1;
                end else begin
                    htrans_d   = HTRANS_NONSEQ;
                    haddr_d    = ch_adr[int'(gnt_idx)*XLEN +: XLEN];
                    hsize_d    = ch_size[int'(gnt_idx)*3 +: 3];
                    hwrite_d   = ch_we[gnt_idx];
                    ap_wdata_d = ch_d[int'(gnt_idx)*XLEN +: XLEN];
                    ap_ch_d    = gnt_idx;
                end
            end
        end else if (dp_vld_q && resp_err && (htrans_q == HTRANS_NONSEQ)) begin
            // First ERROR cycle: drop the pending address phase and let its
            // channel compete again.
            htrans_d        = HTRANS_IDLE;
            busy_d[ap_ch_q] = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            htrans_q   <= HTRANS_IDLE;
            haddr_q    <= '0;
            hsize_q    <= '0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            hbusreq_q  <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            q_q        <= '0;
            busy_q     <= '0;
            ap_ch_q    <= '0;
            ap_wdata_q <= '0;
            dp_vld_q   <= 1'b0;
            dp_ch_q    <= '0;
            dp_we_q    <= 1'b0;
        end else begin
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            hbusreq_q  <= hbusreq_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            q_q        <= q_d;
            busy_q     <= busy_d;
            ap_ch_q    <= ap_ch_d;
            ap_wdata_q <= ap_wdata_d;
            dp_vld_q   <= dp_vld_d;
            dp_ch_q    <= dp_ch_d;
            dp_we_q    <= dp_we_d;
        end
    end

    assign htrans      = htrans_q;
    assign haddr       = haddr_q;
    assign hsize       = hsize_q;
    assign hwrite      = hwrite_q;
    assign hwdata      = hwdata_q;
    assign hbusreq     = hbusreq_q;
    assign ch_ack      = ack_q;
    assign ch_err      = err_q;
    assign ch_q        = q_q;
    assign hburst      = HBURST_SINGLE;
    assign hprot       = HPROT_VAL;
    assign hmasterlock = 1'b0;

endmodule

// File: tb/tb_riscv_biu_arb.sv
module tb_riscv_biu_arb;

    typedef struct {
        int          ch;
        logic        err;
        logic        chk_q;
        logic [31:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic hclk = 1'b0;
    logic hreset_n;
    always #5 hclk = ~hclk;

    // Priority instance: NCH=2, ARB_RR=0
    logic [1:0]  p_req, p_we, p_ack, p_err;
    logic [5:0]  p_size;
    logic [63:0] p_adr, p_d;
    logic [31:0] p_q, p_haddr, p_hwdata, p_hrdata;
    logic        p_hbusreq, p_hgrant, p_hwrite, p_hmlock, p_hready;
    logic [1:0]  p_htrans, p_hresp;
    logic [2:0]  p_hsize, p_hburst;
    logic [3:0]  p_hprot;

    // Round-robin instance: NCH=3, ARB_RR=1
    logic [2:0]  r_req, r_we, r_ack, r_err;
    logic [8:0]  r_size;
    logic [95:0] r_adr, r_d;
    logic [31:0] r_q, r_haddr, r_hwdata, r_hrdata;
    logic        r_hbusreq, r_hgrant, r_hwrite, r_hmlock, r_hready;
    logic [1:0]  r_htrans, r_hresp;
    logic [2:0]  r_hsize, r_hburst;
    logic [3:0]  r_hprot;
    logic        r_auto;

    riscv_biu_arb #(.XLEN(32), .NCH(2), .ARB_RR(0), .HPROT_VAL(4'b0011)) dut_p (
        .hclk(hclk), .hreset_n(hreset_n),
        .ch_req(p_req), .ch_we(p_we), .ch_size(p_size), .ch_adr(p_adr), .ch_d(p_d),
        .ch_q(p_q), .ch_ack(p_ack), .ch_err(p_err),
        .hbusreq(p_hbusreq), .hgrant(p_hgrant), .haddr(p_haddr), .htrans(p_htrans),
        .hsize(p_hsize), .hburst(p_hburst), .hprot(p_hprot), .hwrite(p_hwrite),
        .hwdata(p_hwdata), .hmasterlock(p_hmlock), .hready(p_hready),
        .hrdata(p_hrdata), .hresp(p_hresp)
    );

    riscv_biu_arb #(.XLEN(32), .NCH(3), .ARB_RR(1), .HPROT_VAL(4'b0011)) dut_r (
        .hclk(hclk), .hreset_n(hreset_n),
        .ch_req(r_req), .ch_we(r_we), .ch_size(r_size), .ch_adr(r_adr), .ch_d(r_d),
        .ch_q(r_q), .ch_ack(r_ack), .ch_err(r_err),
        .hbusreq(r_hbusreq), .hgrant(r_hgrant), .haddr(r_haddr), .htrans(r_htrans),
        .hsize(r_hsize), .hburst(r_hburst), .hprot(r_hprot), .hwrite(r_hwrite),
        .hwdata(r_hwdata), .hmasterlock(r_hmlock), .hready(r_hready),
        .hrdata(r_hrdata), .hresp(r_hresp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic err, input logic chk_q, input logic [31:0] q);
        exp_t x;
        x.ch = ch; x.err = err; x.chk_q = chk_q; x.q = q;
        sb.push_back(x);
    endtask

    task automatic set_p(input int ch, input logic we, input logic [2:0] size,
                         input logic [31:0] adr, input logic [31:0] d);
        p_we[ch]          = we;
        p_size[ch*3 +: 3] = size;
        p_adr[ch*32 +: 32] = adr;
        p_d[ch*32 +: 32]  = d;
        p_req[ch]         = 1'b1;
    endtask

    // Advance to the next sampling point; requesters drop a request once acked.
    task automatic cyc();
        @(negedge hclk);
        p_req = p_req & ~p_ack;
        if (r_auto) r_req = r_req & ~r_ack;
    endtask

    // Scoreboard monitor for the priority instance.
    always @(negedge hclk) begin
        if (hreset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (p_ack[k]) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got ack on ch%0d, required none (t=%0t)", k, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_ack_ch", k, e.ch);
                        chk("sb_ack_err", p_err[k], e.err);
                        if (e.chk_q) chk("sb_ack_q", p_q, e.q);
                    end
                end
            end
        end
    end

    int got[$];
    int budget;
    int exp_rr[6];

    initial begin
        hreset_n = 1'b0;
        p_req = '0; p_we = '0; p_size = '0; p_adr = '0; p_d = '0;
        p_hgrant = 1'b1; p_hready = 1'b1; p_hrdata = '0; p_hresp = 2'b00;
        r_req = '0; r_we = 3'b111; r_size = {3'd2, 3'd2, 3'd2};
        r_adr = {32'h30, 32'h20, 32'h10}; r_d = {32'h3, 32'h2, 32'h1};
        r_hgrant = 1'b1; r_hready = 1'b1; r_hrdata = '0; r_hresp = 2'b00;
        r_auto = 1'b1;
        exp_rr = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30};

        repeat (2) @(negedge hclk);
        chk("rst_htrans", p_htrans, 0);
        chk("rst_hbusreq", p_hbusreq, 0);
        chk("rst_ack", p_ack, 0);
        chk("rst_q", p_q, 0);
        chk("const_hburst", p_hburst, 0);
        chk("const_hprot", p_hprot, 4'b0011);
        chk("const_hmlock", p_hmlock, 0);
        hreset_n = 1'b1;
        cyc(); cyc();

        // Single read
        set_p(0, 0, 3'd2, 32'h100, 32'hA5A5A5A5);
        p_hrdata = 32'hDEADBEEF;
        push(0, 0, 1, 32'hDEADBEEF);
        cyc();
        chk("t1_htrans_c1", p_htrans, 2);
        chk("t1_haddr_c1", p_haddr, 32'h100);
        chk("t1_hsize_c1", p_hsize, 2);
        chk("t1_hbusreq_c1", p_hbusreq, 1);
        cyc();
        chk("t1_htrans_c2", p_htrans, 0);
        cyc();
        chk("t1_ack_c3", p_ack, 2'b01);
        repeat (2) cyc();

        // Write ch0 + read ch1 together, priority
        set_p(0, 1, 3'd2, 32'h200, 32'h11112222);
        set_p(1, 0, 3'd2, 32'h204, 32'h33334444);
        p_hrdata = 32'hCAFEF00D;
        push(0, 0, 0, 0);
        push(1, 0, 1, 32'hCAFEF00D);
        cyc();
        chk("t2_htrans_c1", p_htrans, 2);
        chk("t2_haddr_c1", p_haddr, 32'h200);
        chk("t2_hwrite_c1", p_hwrite, 1);
        cyc();
        chk("t2_htrans_c2", p_htrans, 2);
        chk("t2_haddr_c2", p_haddr, 32'h204);
        chk("t2_hwrite_c2", p_hwrite, 0);
        chk("t2_hwdata_c2", p_hwdata, 32'h11112222);
        cyc();
        chk("t2_ack_c3", p_ack, 2'b01);
        cyc();
        chk("t2_ack_c4", p_ack, 2'b10);
        repeat (2) cyc();

        // Misaligned: address and oversize
        set_p(1, 0, 3'd2, 32'h102, 0);
        push(1, 1, 0, 0);
        cyc();
        chk("t4_htrans", p_htrans, 0);
        chk("t4_ack", p_ack, 2'b10);
        chk("t4_err", p_err, 2'b10);
        chk("t4_hbusreq", p_hbusreq, 0);
        cyc();
        set_p(0, 0, 3'd3, 32'h0, 0);
        push(0, 1, 0, 0);
        cyc();
        chk("t4b_htrans", p_htrans, 0);
        chk("t4b_ack", p_ack, 2'b01);
        chk("t4b_err", p_err, 2'b01);
        repeat (2) cyc();

        // Two-cycle ERROR on ch0 with ch1 address pending
        set_p(0, 0, 3'd2, 32'h300, 0);
        set_p(1, 0, 3'd2, 32'h304, 0);
        p_hrdata = 32'h55AA55AA;
        push(0, 1, 0, 0);
        push(1, 0, 1, 32'h55AA55AA);
        cyc();
        chk("t5_haddr_c1", p_haddr, 32'h300);
        cyc();
        chk("t5_htrans_c2", p_htrans, 2);
        chk("t5_haddr_c2", p_haddr, 32'h304);
        p_hready = 1'b0; p_hresp = 2'b01;
        cyc();
        chk("t5_cancel_htrans", p_htrans, 0);
        chk("t5_no_ack_c3", p_ack, 0);
        p_hready = 1'b1;
        cyc();
        chk("t5_ack_c4", p_ack, 2'b01);
        chk("t5_reissue_htrans", p_htrans, 2);
        chk("t5_reissue_haddr", p_haddr, 32'h304);
        p_hresp = 2'b00;
        cyc(); cyc();
        chk("t5_ack_c6", p_ack, 2'b10);
        repeat (2) cyc();

        // Three wait states during ch0 read, ch1 address held
        set_p(0, 0, 3'd2, 32'h400, 0);
        set_p(1, 0, 3'd2, 32'h404, 0);
        p_hrdata = 32'h12345678;
        push(0, 0, 1, 32'h12345678);
        push(1, 0, 1, 32'h12345678);
        cyc();
        chk("t6_haddr_c1", p_haddr, 32'h400);
        cyc();
        p_hready = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            cyc();
            chk("t6_hold_haddr", p_haddr, 32'h404);
            chk("t6_hold_htrans", p_htrans, 2);
            chk("t6_no_ack", p_ack, 0);
        end
        p_hready = 1'b1;
        cyc();
        chk("t6_ack_c6", p_ack, 2'b01);
        cyc();
        chk("t6_ack_c7", p_ack, 2'b10);
        repeat (2) cyc();

        // Reset during a wait state
        set_p(0, 0, 3'd2, 32'h500, 32'h77777777);
        p_hrdata = 32'h9ABCDEF0;
        cyc();
        chk("t7_haddr_c1", p_haddr, 32'h500);
        cyc();
        p_hready = 1'b0;
        cyc();
        hreset_n = 1'b0;
        p_req = '0;
        #1;
        chk("t7_rst_htrans", p_htrans, 0);
        chk("t7_rst_haddr", p_haddr, 0);
        chk("t7_rst_hsize", p_hsize, 0);
        chk("t7_rst_hwrite", p_hwrite, 0);
        chk("t7_rst_hwdata", p_hwdata, 0);
        chk("t7_rst_hbusreq", p_hbusreq, 0);
        chk("t7_rst_ack", p_ack, 0);
        chk("t7_rst_err", p_err, 0);
        chk("t7_rst_q", p_q, 0);
        cyc();
        hreset_n = 1'b1;
        p_hready = 1'b1;
        repeat (5) cyc();
        chk("t7_idle_after", p_htrans, 0);

        // Grant loss: request waits for hgrant
        p_hgrant = 1'b0;
        set_p(0, 0, 3'd2, 32'h600, 0);
        p_hrdata = 32'h0BADF00D;
        push(0, 0, 1, 32'h0BADF00D);
        cyc();
        chk("t8_nogrant_htrans_c1", p_htrans, 0);
        chk("t8_hbusreq_c1", p_hbusreq, 1);
        cyc();
        chk("t8_nogrant_htrans_c2", p_htrans, 0);
        p_hgrant = 1'b1;
        cyc();
        chk("t8_htrans_c3", p_htrans, 2);
        chk("t8_haddr_c3", p_haddr, 32'h600);
        repeat (4) cyc();

        // Round-robin, all channels requesting continuously
        r_auto = 1'b0;
        r_req = 3'b111;
        budget = 0;
        while (got.size() < 6 && budget < 60) begin
            cyc();
            budget++;
            if (r_htrans == 2'b10) got.push_back(int'(r_haddr));
        end
        r_req = '0;
        r_auto = 1'b1;
        chk("rr_count", got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk($sformatf("rr_order_%0d", i), got[i], exp_rr[i]);
        end
        repeat (8) cyc();

        // Park the pointer past ch1, then ch0 and ch2 together: ch2 first
        got.delete();
        r_req = 3'b010;
        budget = 0;
        while (got.size() < 1 && budget < 20) begin
            cyc();
            budget++;
            if (r_htrans == 2'b10) got.push_back(int'(r_haddr));
        end
        chk("rr_single_cnt", got.size(), 1);
        repeat (6) cyc();
        got.delete();
        r_req = 3'b101;
        budget = 0;
        while (got.size() < 2 && budget < 20) begin
            cyc();
            budget++;
            if (r_htrans == 2'b10) got.push_back(int'(r_haddr));
        end
        chk("rr_ptr_cnt", got.size(), 2);
        if (got.size() >= 2) begin
            chk("rr_ptr_first", got[0], 32'h30);
            chk("rr_ptr_second", got[1], 32'h10);
        end
        repeat (6) cyc();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
